nmea_time_decode: RTL
=====================

NMEA_TIME_DECODE -- requirements
Module: nmea_time_decode

Interface
REQ-001 Parameter N_BITS, 8, width of the incoming character bus.
REQ-002 Parameter TIMEOUT_CYCLES, 1000000, maximum idle clk cycles allowed between consecutive digits of one field.
REQ-003 clk  input  1  clock; all logic on the rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 clear  input  1  synchronous re-arm; abandons the current field and returns to IDLE.
REQ-006 info_data  input  N_BITS  ASCII character from the upstream pattern-search stage.
REQ-007 info_valid  input  1  qualifies info_data for one cycle; no backpressure.
REQ-008 hours  output  5  last accepted hours, binary 0..23.
REQ-009 minutes  output  6  last accepted minutes, binary 0..59.
REQ-010 seconds  output  6  last accepted seconds, binary 0..60.
REQ-011 time_valid  output  1  one-cycle pulse when a new time is loaded into hours/minutes/seconds.
REQ-012 time_error  output  1  one-cycle pulse on field rejection.
REQ-013 err_code  output  2  cause of the last rejection: 00 none, 01 non-digit, 10 range, 11 timeout.

Function
REQ-014 The block SHALL decode a 6-character ASCII field "hhmmss" into binary hours, minutes and seconds.
REQ-015 The FSM SHALL have the states IDLE, COLLECT, CHECK and HOLD.
REQ-016 IDLE: on info_valid with a digit, the block SHALL store the digit value as d0 and move to COLLECT with a count of 1.
REQ-017 COLLECT: each info_valid digit SHALL be stored as d[count], and count SHALL increment; on the 6th digit the FSM SHALL move to CHECK.
REQ-018 A digit is any byte from 0x30 to 0x39 inclusive; its value is the byte minus 0x30, 4 bits.
REQ-019 A non-digit byte in IDLE or COLLECT SHALL move the FSM to HOLD, set err_code=01, and pulse time_error on the next cycle.
REQ-020 CHECK (one cycle): the block SHALL compute hh=10*d0+d1, mm=10*d2+d3 and ss=10*d4+d5, with 7-bit intermediates.
REQ-021 Range check: the field SHALL be accepted only if hh<=23, mm<=59 and ss<=60 (60 allows a leap second).
REQ-022 On pass, outputs SHALL load on the cycle after CHECK, time_valid SHALL pulse in that same cycle, and err_code SHALL become 00.
REQ-023 On fail, time_error SHALL pulse, err_code SHALL become 10, and hours/minutes/seconds SHALL keep their previous values.
REQ-024 Latency: the 6th digit is accepted at edge N; CHECK occupies cycle N+1; the time_valid or time_error pulse is high during cycle N+2.
REQ-025 After CHECK the FSM SHALL enter HOLD.
REQ-026 Timeout: a counter SHALL reset on every accepted byte and increment each cycle in COLLECT.
REQ-027 When the timeout counter reaches TIMEOUT_CYCLES, the FSM SHALL enter HOLD, set err_code=11, and pulse time_error on the next cycle.
REQ-028 The timeout counter width SHALL be clog2(TIMEOUT_CYCLES+1); it SHALL NOT count in IDLE or HOLD.
REQ-029 info_valid SHALL be ignored in CHECK and in HOLD.
REQ-030 HOLD is exited only by clear or rst.
REQ-031 clear in any state SHALL set the FSM to IDLE, count to 0 and the timeout counter to 0.
REQ-032 clear SHALL NOT alter hours, minutes, seconds or err_code.
REQ-033 clear together with info_valid SHALL give priority to clear; the byte is dropped.
REQ-034 time_valid and time_error SHALL never be high in the same cycle.

Reset
REQ-035 rst SHALL force the FSM to IDLE, count=0, timeout counter=0 and the digit registers to 0.
REQ-036 rst SHALL force hours=0, minutes=0, seconds=0, time_valid=0, time_error=0 and err_code=00.
REQ-037 rst mid-field SHALL discard all partial digits, with no pulse generated.
REQ-038 rst SHALL take priority over clear and info_valid.

Structure
REQ-039 A shared package nmea_pkg SHALL hold the FSM state encoding, the err_code constants, ASCII_0=0x30, ASCII_9=0x39, and the limits MAX_HH=23, MAX_MM=59, MAX_SS=60.
REQ-040 One combinational sub-module, nmea_digit_check, SHALL map an N_BITS byte to an is_digit flag and a 4-bit value; the digit detection SHALL be instantiated once.

Verification
REQ-041 "123456", one byte every 4 cycles -> time_valid pulse 2 cycles after the last byte; hours=12, minutes=34, seconds=56, err_code=00.
REQ-042 "235960", then clear, then "240000" -> first gives a valid 23:59:60; second gives time_error with err_code=10, and outputs stay 23:59:60.
REQ-043 "12:456" -> time_error one cycle after ':'; err_code=01; the remaining bytes are ignored; no time_valid occurs until clear.
REQ-044 "123" then info_valid low for TIMEOUT_CYCLES (parameter set to 16 in the bench) -> time_error with err_code=11; subsequent bytes are ignored until clear.
REQ-045 "12" then clear coincident with a '3' byte, then "000000" -> the '3' is dropped; time_valid with 00:00:00.
REQ-046 rst asserted after 4 digits -> all outputs 0 and no pulse; then "010203" -> time_valid with 01:02:03.

Source files
------------

// File: rtl/nmea_pkg.sv
// nmea_pkg
//   Shared definitions for the NMEA time-field decoder: FSM state encoding,
//   err_code values, ASCII digit bounds, range limits for hh/mm/ss and a
//   helper that folds two BCD-style digits into a binary value.
package nmea_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_CHECK   = 2'd2,
    ST_HOLD    = 2'd3
  } state_e;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_DIGIT   = 2'b01;
  localparam logic [1:0] ERR_RANGE   = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

  localparam logic [7:0] ASCII_0 = 8'h30;
  localparam logic [7:0] ASCII_9 = 8'h39;

  localparam logic [6:0] MAX_HH = 7'd23;
  localparam logic [6:0] MAX_MM = 7'd59;
  localparam logic [6:0] MAX_SS = 7'd60;  // 60 admits a leap second

  localparam int unsigned N_DIGITS = 6;

  // 10*tens + units; the largest result (99) fits the 7-bit intermediate.
  function automatic logic [6:0] two_digit(input logic [3:0] tens,
                                           input logic [3:0] units);
    return ({3'b000, tens} * 7'd10) + {3'b000, units};
  endfunction

endpackage

// File: rtl/nmea_time_decode_if.sv
// nmea_time_decode_if
//   Bundles the character stream into the decoder and the decoded time
//   results coming back out.
//   master: drives info_data/info_valid, observes the time outputs.
//   slave : the decoder; receives characters, drives the time outputs.
interface nmea_time_decode_if #(
  parameter int N_BITS = 8
);
  logic [N_BITS-1:0] info_data;
  logic              info_valid;
  logic [4:0]        hours;
  logic [5:0]        minutes;
  logic [5:0]        seconds;
  logic              time_valid;
  logic              time_error;
  logic [1:0]        err_code;

  modport master (
    output info_data, info_valid,
    input  hours, minutes, seconds, time_valid, time_error, err_code
  );

  modport slave (
    input  info_data, info_valid,
    output hours, minutes, seconds, time_valid, time_error, err_code
  );
endinterface

// File: rtl/nmea_digit_check.sv
// nmea_digit_check
//   Purely combinational ASCII digit classifier.
//   char_data   : N_BITS character
//   is_digit    : high when char_data lies in '0'..'9'
//   digit_value : binary value of the digit, 0 when not a digit
module nmea_digit_check
  import nmea_pkg::*;
#(
  parameter int N_BITS = 8
) (
  input  logic [N_BITS-1:0] char_data,
  output logic              is_digit,
  output logic [3:0]        digit_value
);

  // Classify the byte; inside 0x30..0x39 the low nibble already is the value.
  always_comb begin
    is_digit    = (char_data >= N_BITS'(ASCII_0)) && (char_data <= N_BITS'(ASCII_9));
    if (is_digit) begin
      digit_value = char_data[3:0];
    end else begin
      digit_value = 4'd0;
    end
  end

endmodule

// File: rtl/nmea_time_decode.sv
// nmea_time_decode
//   Decodes a 6-character ASCII "hhmmss" field into binary hours, minutes
//   and seconds with digit, range and inter-digit timeout checking.
//   clk   : clock, rising edge
//   rst   : synchronous active-high reset, highest priority
//   clear : synchronous re-arm; abandons the field, keeps last time/err_code
//   bus   : slave side of nmea_time_decode_if (info_data/info_valid in,
//           hours/minutes/seconds/time_valid/time_error/err_code out)
//   Every output is driven straight from a register.
module nmea_time_decode
  import nmea_pkg::*;
#(
  parameter int N_BITS         = 8,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  nmea_time_decode_if.slave       bus
);

  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(TIMEOUT_CYCLES);

  state_e           state_r, state_s;
  logic [2:0]       count_r, count_s;
  logic [TMO_W-1:0] tmo_r, tmo_s;
  logic [3:0]       digit_r [N_DIGITS];
  logic [3:0]       digit_s [N_DIGITS];
  logic [4:0]       hours_r, hours_s;
  logic [5:0]       minutes_r, minutes_s;
  logic [5:0]       seconds_r, seconds_s;
  logic             time_valid_r, time_valid_s;
  logic             time_error_r, time_error_s;
  logic [1:0]       err_code_r, err_code_s;

  logic             is_digit_s;
  logic [3:0]       digit_val_s;
  logic [6:0]       hh_s, mm_s, ss_s;
  logic             range_ok_s;

  nmea_digit_check #(
    .N_BITS(N_BITS)
  ) u_digit_check (
    .char_data   (bus.info_data),
    .is_digit    (is_digit_s),
    .digit_value (digit_val_s)
  );

  // Binary field values and range verdict, consumed only in CHECK.
  always_comb begin
    hh_s       = two_digit(digit_r[0], digit_r[1]);
    mm_s       = two_digit(digit_r[2], digit_r[3]);
    ss_s       = two_digit(digit_r[4], digit_r[5]);
    range_ok_s = (hh_s <= MAX_HH) && (mm_s <= MAX_MM) && (ss_s <= MAX_SS);
  end

  // Next-state and next-output logic; clear overrides every state.
  always_comb begin
    state_s      = state_r;
    count_s      = count_r;
    tmo_s        = tmo_r;
    digit_s      = digit_r;
    hours_s      = hours_r;
    minutes_s    = minutes_r;
    seconds_s    = seconds_r;
    time_valid_s = 1'b0;
    time_error_s = 1'b0;
    err_code_s   = err_code_r;

    if (clear) begin
      state_s = ST_IDLE;
      count_s = 3'd0;
      tmo_s   = '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.info_valid) begin
            if (is_digit_s) begin
              digit_s[0] = digit_val_s;
              count_s    = 3'd1;
              tmo_s      = '0;
              state_s    = ST_COLLECT;
            end else begin
              state_s      = ST_HOLD;
              err_code_s   = ERR_DIGIT;
              time_error_s = 1'b1;
            end
          end else begin
            state_s = ST_IDLE;
          end
        end

        ST_COLLECT: begin
          if (bus.info_valid) begin
            if (is_digit_s) begin
              // Loop compare keeps the write index inside the array bounds.
              for (int i = 0; i < N_DIGITS; i++) begin
                if (count_r == 3'(i)) begin
                  digit_s[i] = digit_val_s;
                end else begin
                  digit_s[i] = digit_r[i];
                end
              end
              count_s = count_r + 3'd1;
              tmo_s   = '0;
              if (count_r == 3'(N_DIGITS - 1)) begin
                state_s = ST_CHECK;
              end else begin
                state_s = ST_COLLECT;
              end
            end else begin
              state_s      = ST_HOLD;
              err_code_s   = ERR_DIGIT;
              time_error_s = 1'b1;
            end
          end else if (tmo_r == TMO_LIMIT) begin
            // TIMEOUT_CYCLES idle cycles were tolerated; one more is too many.
            state_s      = ST_HOLD;
            err_code_s   = ERR_TIMEOUT;
            time_error_s = 1'b1;
          end else begin
            tmo_s = tmo_r + TMO_W'(1);
          end
        end

        ST_CHECK: begin
          state_s = ST_HOLD;
          if (range_ok_s) begin
            hours_s      = hh_s[4:0];
            minutes_s    = mm_s[5:0];
            seconds_s    = ss_s[5:0];
            time_valid_s = 1'b1;
            err_code_s   = ERR_NONE;
          end else begin
            time_error_s = 1'b1;
            err_code_s   = ERR_RANGE;
          end
        end

        ST_HOLD: begin
          state_s = ST_HOLD;
        end

        default: begin
          state_s = ST_IDLE;
          count_s = 3'd0;
          tmo_s   = '0;
        end
      endcase
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      count_r      <= 3'd0;
      tmo_r        <= '0;
      digit_r      <= '{default: 4'd0};
      hours_r      <= 5'd0;
      minutes_r    <= 6'd0;
      seconds_r    <= 6'd0;
      time_valid_r <= 1'b0;
      time_error_r <= 1'b0;
      err_code_r   <= ERR_NONE;
    end else begin
      state_r      <= state_s;
      count_r      <= count_s;
      tmo_r        <= tmo_s;
      digit_r      <= digit_s;
      hours_r      <= hours_s;
      minutes_r    <= minutes_s;
      seconds_r    <= seconds_s;
      time_valid_r <= time_valid_s;
      time_error_r <= time_error_s;
      err_code_r   <= err_code_s;
    end
  end

  assign bus.hours      = hours_r;
  assign bus.minutes    = minutes_r;
  assign bus.seconds    = seconds_r;
  assign bus.time_valid = time_valid_r;
  assign bus.time_error = time_error_r;
  assign bus.err_code   = err_code_r;

endmodule
